mem_port_arbiter: RTL and testbench

//  Shares the single-ported unified core memory between instruction fetch and data load/store.

---
 rtl/octo_mem_pkg.sv | 19 +
 rtl/mem_addr_check.sv | 32 +++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/octo_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   state_e           : sequencing FSM encoding (idle, access, wait, response)
//   DEFAULT_ADDR_BASE : byte address of memory word 0
//   REQ_IF / REQ_D    : requester identifiers recorded at accept
package octo_mem_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational bounds/alignment check for a byte address.
//   i_addr     : byte address to check
//   o_legal    : 1 when ADDR_BASE <= addr < ADDR_BASE + 4*MEM_WORDS and word aligned
//   o_word_idx : (addr - ADDR_BASE) >> 2, meaningful only when o_legal is 1
module mem_addr_check
  import octo_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEFAULT_ADDR_BASE,
  parameter int unsigned MEM_WORDS = 65536,
  localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
  input  logic [31:0]   i_addr,
  output logic          o_legal,
  output logic [AW-1:0] o_word_idx
);

  logic [32:0] w_addr_ext;
  logic [32:0] w_lo;
  logic [32:0] w_hi;
  logic [31:0] w_offset;

  // 33-bit compare so a memory ending at 4 GiB does not wrap the upper bound.
  assign w_addr_ext = {1'b0, i_addr};
  assign w_lo       = {1'b0, ADDR_BASE};
  assign w_hi       = w_lo + (33'(MEM_WORDS) << 2);

  assign w_offset   = i_addr - ADDR_BASE;
  assign o_word_idx = AW'(w_offset >> 2);

  assign o_legal = (w_addr_ext >= w_lo) && (w_addr_ext < w_hi) && (i_addr[1:0] == 2'b00);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported core memory between instruction fetch and data load/store.
// One access outstanding at a time; each response returns on the granted requester's port.
//   i_clock, i_reset                      : clock, asynchronous active-high reset
//   i_if_req_* / o_if_req_ready           : fetch request channel
//   o_if_rsp_valid/_data/_err             : fetch response pulse
//   i_d_req_* / o_d_req_ready             : data request channel (we, wdata, wstrb)
//   o_d_rsp_valid/_data/_err              : data response pulse
//   o_mem_en/_we/_addr/_wdata, i_mem_rdata: memory array interface
module mem_port_arbiter
  import octo_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = DEFAULT_ADDR_BASE,
  parameter int unsigned MEM_WORDS    = 65536,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned AW          = $clog2(MEM_WORDS)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_if_req_valid,
  output logic          o_if_req_ready,
  input  logic [31:0]   i_if_req_addr,
  output logic          o_if_rsp_valid,
  output logic [31:0]   o_if_rsp_data,
  output logic          o_if_rsp_err,
  input  logic          i_d_req_valid,
  output logic          o_d_req_ready,
  input  logic [31:0]   i_d_req_addr,
  input  logic          i_d_req_we,
  input  logic [31:0]   i_d_req_wdata,
  input  logic [3:0]    i_d_req_wstrb,
  output logic          o_d_rsp_valid,
  output logic [31:0]   o_d_rsp_data,
  output logic          o_d_rsp_err,
  output logic          o_mem_en,
  output logic [3:0]    o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e           r_state;
  logic [SCW-1:0]   r_starve_cnt;
  logic [LCW-1:0]   r_lat_cnt;
  logic             r_req_id;
  logic             r_is_store;

  logic             w_at_limit;
  logic             w_sel_if;
  logic             w_sel_d;
  logic             w_idle;
  logic             w_if_acc;
  logic             w_d_acc;
  logic             w_store;
  logic [31:0]      w_addr;
  logic             w_legal;
  logic [AW-1:0]    w_word_idx;

  // Data wins unless fetch has waited through STARVE_LIMIT data grants.
  assign w_at_limit = (r_starve_cnt == SCW'(STARVE_LIMIT));
  assign w_sel_if   = i_if_req_valid && (!i_d_req_valid || w_at_limit);
  assign w_sel_d    = i_d_req_valid && !w_sel_if;

  // Ready is forced low during reset so every output reads 0 while it is held.
  assign w_idle   = (r_state == StIdle) && !i_reset;
  assign w_if_acc = w_idle && w_sel_if;
  assign w_d_acc  = w_idle && w_sel_d;
  assign w_store  = w_d_acc && i_d_req_we;

  assign o_if_req_ready = w_if_acc;
  assign o_d_req_ready  = w_d_acc;

  assign w_addr = w_sel_if ? i_if_req_addr : i_d_req_addr;

  mem_addr_check #(
    .ADDR_BASE (ADDR_BASE),
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_check (
    .i_addr     (w_addr),
    .o_legal    (w_legal),
    .o_word_idx (w_word_idx)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_starve_cnt   <= '0;
      r_lat_cnt      <= '0;
      r_req_id       <= REQ_IF;
      r_is_store     <= 1'b0;
      o_if_rsp_valid <= 1'b0;
      o_if_rsp_data  <= '0;
      o_if_rsp_err   <= 1'b0;
      o_d_rsp_valid  <= 1'b0;
      o_d_rsp_data   <= '0;
      o_d_rsp_err    <= 1'b0;
      o_mem_en       <= 1'b0;
      o_mem_we       <= '0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
    end else begin
      // Response flags are single-cycle pulses; data holds until the next response.
      o_if_rsp_valid <= 1'b0;
      o_if_rsp_err   <= 1'b0;
      o_d_rsp_valid  <= 1'b0;
      o_d_rsp_err    <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_if_acc || w_d_acc) begin
            r_req_id   <= w_if_acc ? REQ_IF : REQ_D;
            r_is_store <= w_store;

            if (w_if_acc) begin
              r_starve_cnt <= '0;
            end else if (i_if_req_valid && !w_at_limit) begin
              r_starve_cnt <= r_starve_cnt + SCW'(1);
            end

            if (w_legal) begin
              r_state     <= StAccess;
              o_mem_en    <= 1'b1;
              o_mem_we    <= w_store ? i_d_req_wstrb : 4'b0000;
              o_mem_addr  <= w_word_idx;
              o_mem_wdata <= w_store ? i_d_req_wdata : 32'h0;
            end else begin
              // Illegal address: skip the memory, answer with an error next cycle.
              r_state <= StResp;
              if (w_if_acc) begin
                o_if_rsp_valid <= 1'b1;
                o_if_rsp_err   <= 1'b1;
                o_if_rsp_data  <= '0;
              end else begin
                o_d_rsp_valid <= 1'b1;
                o_d_rsp_err   <= 1'b1;
                o_d_rsp_data  <= '0;
              end
            end
          end
        end

        StAccess: begin
          o_mem_en  <= 1'b0;
          o_mem_we  <= '0;
          r_lat_cnt <= LCW'(MEM_LATENCY - 1);
          r_state   <= StWait;
        end

        StWait: begin
          // Count down to the cycle in which mem_rdata is valid, then capture it.
          if (r_lat_cnt == '0) begin
            r_state <= StResp;
            if (r_req_id == REQ_IF) begin
              o_if_rsp_valid <= 1'b1;
              o_if_rsp_data  <= i_mem_rdata;
            end else begin
              o_d_rsp_valid <= 1'b1;
              o_d_rsp_data  <= r_is_store ? 32'h0 : i_mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LCW'(1);
          end
        end

        StResp: begin
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed and randomized transactions checked
// against a word-array reference model and timing rules derived from the latency contract.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam longint      BASE_L = 64'h8000_0000;
  localparam int          WORDS  = 65536;
  localparam int          LAT    = 1;
  localparam int          LIMIT  = 4;
  localparam int          AW     = 16;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_if_req_valid = 1'b0;
  logic [31:0]   i_if_req_addr = '0;
  logic          i_d_req_valid = 1'b0;
  logic [31:0]   i_d_req_addr = '0;
  logic          i_d_req_we = 1'b0;
  logic [31:0]   i_d_req_wdata = '0;
  logic [3:0]    i_d_req_wstrb = '0;
  logic [31:0]   i_mem_rdata = '0;
  logic          o_if_req_ready, o_if_rsp_valid, o_if_rsp_err;
  logic [31:0]   o_if_rsp_data;
  logic          o_d_req_ready, o_d_rsp_valid, o_d_rsp_err;
  logic [31:0]   o_d_rsp_data;
  logic          o_mem_en;
  logic [3:0]    o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;

  int n_cmp = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .ADDR_BASE    (BASE),
    .MEM_WORDS    (WORDS),
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_if_req_valid (i_if_req_valid),
    .o_if_req_ready (o_if_req_ready),
    .i_if_req_addr  (i_if_req_addr),
    .o_if_rsp_valid (o_if_rsp_valid),
    .o_if_rsp_data  (o_if_rsp_data),
    .o_if_rsp_err   (o_if_rsp_err),
    .i_d_req_valid  (i_d_req_valid),
    .o_d_req_ready  (o_d_req_ready),
    .i_d_req_addr   (i_d_req_addr),
    .i_d_req_we     (i_d_req_we),
    .i_d_req_wdata  (i_d_req_wdata),
    .i_d_req_wstrb  (i_d_req_wstrb),
    .o_d_rsp_valid  (o_d_rsp_valid),
    .o_d_rsp_data   (o_d_rsp_data),
    .o_d_rsp_err    (o_d_rsp_err),
    .o_mem_en       (o_mem_en),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents are init_word(i) ^ delta[i]; zero-filled 2-state deltas need no init.
  bit [31:0] phys_delta [WORDS];
  bit [31:0] ref_delta  [WORDS];

  function automatic logic [31:0] init_word(input int unsigned i);
    return 32'hC0DE_0000 ^ 32'(i * 32'h9E37_79B9);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] idx);
    return init_word(32'(idx)) ^ ref_delta[idx];
  endfunction

  function automatic logic [31:0] phys_rd(input logic [AW-1:0] idx);
    return init_word(32'(idx)) ^ phys_delta[idx];
  endfunction

  function automatic bit addr_legal(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= BASE_L) && (la < BASE_L + 4 * longint'(WORDS)) && (la % 4 == 0);
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    longint la;
    la = (longint'(a) - BASE_L) / 4;
    return AW'(la);
  endfunction

  // Memory array responder: read data valid LAT (=1) cycle after mem_en.
  always @(posedge clk) begin
    if (o_mem_en) begin
      i_mem_rdata <= phys_rd(o_mem_addr);
      if (o_mem_we != 4'b0000)
        phys_delta[o_mem_addr] <= merge(phys_rd(o_mem_addr), o_mem_wdata, o_mem_we)
                                  ^ init_word(32'(o_mem_addr));
    end
  end

  // Observations of the last single transaction (cycle 0 = accept cycle).
  bit          ob_rdy;
  int          ob_t_mem, ob_n_mem, ob_t_rsp, ob_n_rsp;
  bit          ob_stray, ob_err;
  logic [31:0] ob_data, ob_mwdata;
  logic [AW-1:0] ob_maddr;
  logic [3:0]  ob_mwe;

  task automatic drive_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    bit got;
    ob_rdy = 0; ob_t_mem = -1; ob_n_mem = 0; ob_t_rsp = -1; ob_n_rsp = 0;
    ob_stray = 0; ob_err = 0; ob_data = '0; ob_mwdata = '0; ob_maddr = '0; ob_mwe = '0;
    @(negedge clk);
    if (is_d) begin
      i_d_req_valid = 1; i_d_req_addr = addr; i_d_req_we = we;
      i_d_req_wdata = wdata; i_d_req_wstrb = strb;
    end else begin
      i_if_req_valid = 1; i_if_req_addr = addr;
    end
    got = 0;
    for (int w = 0; w < 10 && !got; w++) begin
      if (w > 0) @(negedge clk);
      #1;
      if (is_d ? o_d_req_ready : o_if_req_ready) begin
        got = 1;
        ob_rdy = !(is_d ? o_if_req_ready : o_d_req_ready);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Drop the request and scramble its fields: the DUT must have captured them.
        i_d_req_valid = 0; i_if_req_valid = 0;
        i_d_req_addr = $urandom(); i_if_req_addr = $urandom();
        i_d_req_wdata = $urandom(); i_d_req_wstrb = 4'($urandom_range(0, 15));
        i_d_req_we = 1'($urandom_range(0, 1));
      end
      #1;
      if (o_mem_en) begin
        ob_n_mem++;
        if (ob_t_mem < 0) begin
          ob_t_mem = k; ob_maddr = o_mem_addr; ob_mwe = o_mem_we; ob_mwdata = o_mem_wdata;
        end
      end
      if (is_d ? o_d_rsp_valid : o_if_rsp_valid) begin
        ob_n_rsp++;
        if (ob_t_rsp < 0) begin
          ob_t_rsp = k;
          ob_data = is_d ? o_d_rsp_data : o_if_rsp_data;
          ob_err = is_d ? o_d_rsp_err : o_if_rsp_err;
        end
      end
      if (is_d ? o_if_rsp_valid : o_d_rsp_valid) ob_stray = 1;
    end
    i_d_req_we = 0;
  endtask

  task automatic test_reset;
    logic [122:0] v;
    #2;
    v = {o_if_req_ready, o_if_rsp_valid, o_if_rsp_data, o_if_rsp_err, o_d_req_ready,
         o_d_rsp_valid, o_d_rsp_data, o_d_rsp_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata};
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", v); end
    repeat (2) @(negedge clk);
    i_reset = 0;
  endtask

  task automatic test_both_valid;
    int t_drsp, t_ifrdy, t_ifrsp;
    logic [31:0] dd, ifd;
    t_drsp = -1; t_ifrdy = -1; t_ifrsp = -1; dd = '0; ifd = '0;
    @(negedge clk);
    i_d_req_valid = 1; i_d_req_we = 0; i_d_req_addr = BASE + 32'd8;
    i_if_req_valid = 1; i_if_req_addr = BASE + 32'd12;
    #1;
    n_cmp++;
    if ({o_d_req_ready, o_if_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL both_ready: got d/if %b want 10", {o_d_req_ready, o_if_req_ready});
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) i_d_req_valid = 0;
      if (t_ifrdy > 0 && k == t_ifrdy + 1) i_if_req_valid = 0;
      #1;
      if (o_d_rsp_valid && t_drsp < 0) begin t_drsp = k; dd = o_d_rsp_data; end
      if (o_if_req_ready && t_ifrdy < 0) t_ifrdy = k;
      if (o_if_rsp_valid && t_ifrsp < 0) begin t_ifrsp = k; ifd = o_if_rsp_data; end
    end
    i_if_req_valid = 0;
    n_cmp++;
    if (t_drsp !== 2 + LAT) begin n_fail++; $display("FAIL both_d_rsp_cycle: got %0d want %0d", t_drsp, 2 + LAT); end
    n_cmp++;
    if (dd !== ref_rd(16'd2)) begin n_fail++; $display("FAIL both_d_data: got %h want %h", dd, ref_rd(16'd2)); end
    n_cmp++;
    if (t_ifrdy !== 3 + LAT) begin n_fail++; $display("FAIL both_if_ready_cycle: got %0d want %0d", t_ifrdy, 3 + LAT); end
    n_cmp++;
    if (t_ifrsp !== 5 + 2 * LAT) begin n_fail++; $display("FAIL both_if_rsp_cycle: got %0d want %0d", t_ifrsp, 5 + 2 * LAT); end
    n_cmp++;
    if (ifd !== ref_rd(16'd3)) begin n_fail++; $display("FAIL both_if_data: got %h want %h", ifd, ref_rd(16'd3)); end
  endtask

  task automatic test_starve;
    int grants [10];
    int n, both, cnt, exp_g;
    n = 0; both = 0;
    @(negedge clk);
    i_d_req_valid = 1; i_d_req_we = 0; i_d_req_addr = BASE + 32'd4;
    i_if_req_valid = 1; i_if_req_addr = BASE;
    for (int k = 0; k < 100 && n < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (o_d_req_ready && o_if_req_ready) both++;
      else if (o_d_req_ready) begin grants[n] = 1; n++; end
      else if (o_if_req_ready) begin grants[n] = 0; n++; end
    end
    @(negedge clk);
    i_d_req_valid = 0; i_if_req_valid = 0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (n !== 10 || both !== 0) begin
      n_fail++; $display("FAIL starve_grants: got %0d grants (%0d double) want 10 (0)", n, both);
    end
    // Fetch waits on every data grant here, so it wins after each run of LIMIT data grants.
    cnt = 0;
    for (int g = 0; g < n; g++) begin
      if (cnt == LIMIT) begin exp_g = 0; cnt = 0; end
      else begin exp_g = 1; cnt++; end
      n_cmp++;
      if (grants[g] !== exp_g) begin
        n_fail++; $display("FAIL starve_grant%0d: got %0d want %0d (1=data)", g, grants[g], exp_g);
      end
    end
  endtask

  task automatic test_txn_stream;
    localparam int NDIR = 9;
    localparam int NRAND = 30;
    bit          dir_is_d [NDIR] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    bit          dir_we   [NDIR] = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
    logic [31:0] dir_addr [NDIR] = '{32'h8000_0000, 32'h0000_1000, 32'h8000_0002,
                                     32'h8003_FFFC, 32'h8003_FFFC, 32'h8004_0000,
                                     32'h8000_0010, 32'h8000_0010, 32'hFFFF_FFFC};
    logic [3:0]  dir_strb [NDIR] = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    bit is_d, we, legal, st;
    logic [31:0] addr, wdata, exp_data;
    logic [3:0] strb;
    logic [AW-1:0] idx;
    for (int i = 0; i < NDIR + NRAND; i++) begin
      if (i < NDIR) begin
        is_d = dir_is_d[i]; we = dir_we[i]; addr = dir_addr[i]; strb = dir_strb[i];
      end else begin
        is_d = 1'($urandom_range(0, 1));
        we = is_d && ($urandom_range(0, 1) == 1);
        strb = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
          6:       addr = BASE + 32'(4 * (WORDS - 1));
          7:       addr = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
          8:       addr = 32'($urandom_range(0, 32'h1FFF_FFFF)) << 2;
          9:       addr = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 1000));
          default: addr = BASE + 32'(4 * $urandom_range(0, 15));
        endcase
      end
      wdata = $urandom();
      legal = addr_legal(addr);
      idx = word_of(addr);
      st = is_d && we;
      exp_data = (legal && !st) ? ref_rd(idx) : 32'h0;
      drive_txn(is_d, we, addr, wdata, strb);
      n_cmp++;
      if (ob_rdy !== 1'b1) begin n_fail++; $display("FAIL txn%0d ready: got %0b want 1", i, ob_rdy); end
      n_cmp++;
      if (ob_n_mem !== (legal ? 1 : 0)) begin
        n_fail++; $display("FAIL txn%0d mem_en_count: got %0d want %0d", i, ob_n_mem, legal ? 1 : 0);
      end
      if (legal) begin
        n_cmp++;
        if (ob_t_mem !== 1) begin n_fail++; $display("FAIL txn%0d mem_en_cycle: got %0d want 1", i, ob_t_mem); end
        n_cmp++;
        if (ob_maddr !== idx) begin n_fail++; $display("FAIL txn%0d mem_addr: got %0d want %0d", i, ob_maddr, idx); end
        n_cmp++;
        if (ob_mwe !== (st ? strb : 4'b0000)) begin
          n_fail++; $display("FAIL txn%0d mem_we: got %b want %b", i, ob_mwe, st ? strb : 4'b0000);
        end
        if (st) begin
          n_cmp++;
          if (ob_mwdata !== wdata) begin n_fail++; $display("FAIL txn%0d mem_wdata: got %h want %h", i, ob_mwdata, wdata); end
        end
      end
      n_cmp++;
      if (ob_t_rsp !== (legal ? 2 + LAT : 1)) begin
        n_fail++; $display("FAIL txn%0d rsp_cycle: got %0d want %0d", i, ob_t_rsp, legal ? 2 + LAT : 1);
      end
      n_cmp++;
      if (ob_n_rsp !== 1) begin n_fail++; $display("FAIL txn%0d rsp_count: got %0d want 1", i, ob_n_rsp); end
      n_cmp++;
      if (ob_data !== exp_data) begin n_fail++; $display("FAIL txn%0d rsp_data: got %h want %h", i, ob_data, exp_data); end
      n_cmp++;
      if (ob_err !== !legal) begin n_fail++; $display("FAIL txn%0d rsp_err: got %0b want %0b", i, ob_err, !legal); end
      n_cmp++;
      if (ob_stray !== 1'b0) begin n_fail++; $display("FAIL txn%0d other_port_rsp: got 1 want 0", i); end
      if (legal && st) ref_delta[idx] = merge(ref_rd(idx), wdata, strb) ^ init_word(32'(idx));
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [122:0] v;
    int stale;
    stale = 0;
    @(negedge clk);
    i_d_req_valid = 1; i_d_req_we = 0; i_d_req_addr = BASE + 32'd20;
    #1;
    n_cmp++;
    if (o_d_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ready: got %0b want 1", o_d_req_ready); end
    @(negedge clk);
    i_d_req_valid = 0;
    #1;
    n_cmp++;
    if (o_mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mem_en: got %0b want 1", o_mem_en); end
    @(negedge clk);
    #1;
    i_reset = 1;
    #1;
    v = {o_if_req_ready, o_if_rsp_valid, o_if_rsp_data, o_if_rsp_err, o_d_req_ready,
         o_d_rsp_valid, o_d_rsp_data, o_d_rsp_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata};
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", v); end
    repeat (2) @(negedge clk);
    i_reset = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (o_if_rsp_valid || o_d_rsp_valid || o_mem_en) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin n_fail++; $display("FAIL rst_stale_activity: got %0d cycles want 0", stale); end
    drive_txn(1'b1, 1'b0, BASE + 32'd24, 32'h0, 4'h0);
    n_cmp++;
    if (ob_t_rsp !== 2 + LAT) begin n_fail++; $display("FAIL rst_after_rsp_cycle: got %0d want %0d", ob_t_rsp, 2 + LAT); end
    n_cmp++;
    if (ob_data !== ref_rd(16'd6) || ob_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_after_data: got %h err %0b want %h err 0", ob_data, ob_err, ref_rd(16'd6));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_both_valid();
    test_starve();
    test_txn_stream();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
